fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and drives a single-outstanding-request instruction-memory handshake.
- Delivers fetched instructions into decode, where the branch comparator and jump logic resolve control flow.
- Consumes the decode-stage redirect (taken branch/jump target) with MIPS delay-slot semantics, and the exception flush from the CP0 path.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_pc_sel.sv | 27 ++
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types, reset constants and PC helper for the fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_KILL = 2'd3
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^32 without any flag.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - single-outstanding instruction-memory request/response bundle
interface fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    // Fetch side issues requests and takes responses.
    modport master (
        output inst_req,
        output inst_addr,
        input  inst_rdata,
        input  inst_data_ok
    );

    // Memory side answers them.
    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_rdata,
        output inst_data_ok
    );

endinterface

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - next-PC priority mux: exception > bypassed redirect > pending redirect > pc+4
module fetch_pc_sel
    import fetch_stage_pkg::*;
(
    input  logic        exc_flush,
    input  logic [31:0] exc_pc,
    input  logic        redirect_d,
    input  logic [31:0] target_d,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  logic [31:0] pc_f,
    output logic [31:0] next_pc
);

    // Highest-priority source wins; a same-cycle redirect bypasses the pending register.
    always_comb begin
        next_pc = pc_plus4(pc_f);
        if (exc_flush) begin
            next_pc = exc_pc;
        end else if (redirect_d) begin
            next_pc = target_d;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage and IF/ID register; optional FETCH_ADEL_CHECK_EN address-error check
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall_d,
    input  logic                 redirect_d,
    input  logic [31:0]          target_d,
    input  logic                 exc_flush,
    input  logic [31:0]          exc_pc,
    output logic [31:0]          pc_f,
    output logic [31:0]          instr_d,
    output logic [31:0]          pc_d,
    output logic [31:0]          pcplus4_d,
    output logic                 valid_d,
    output logic                 adel_d
);

`ifdef FETCH_ADEL_CHECK_EN
    localparam logic ADEL_EN = 1'b1;
`else
    localparam logic ADEL_EN = 1'b0;
`endif

    fetch_state_t state_q;
    logic         req_q;
    logic [31:0]  addr_q;
    logic         pend_valid_q;
    logic [31:0]  pend_target_q;
    logic [31:0]  hold_word_q;
    logic         parked_q;
    logic         adel_q;
    logic [31:0]  next_pc;
    logic         adel_hit;

    fetch_pc_sel u_pc_sel (
        .exc_flush   (exc_flush),
        .exc_pc      (exc_pc),
        .redirect_d  (redirect_d),
        .target_d    (target_d),
        .pend_valid  (pend_valid_q),
        .pend_target (pend_target_q),
        .pc_f        (pc_f),
        .next_pc     (next_pc)
    );

    assign imem.inst_req  = req_q;
    assign imem.inst_addr = addr_q;
    assign pcplus4_d      = pc_plus4(pc_d);
    assign adel_d         = ADEL_EN & adel_q;

    // A misaligned PC is never sent to memory when the address check is built in.
    assign adel_hit = ADEL_EN & (pc_f[1:0] != 2'b00);

    // Fetch FSM, PC, pending redirect, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_IDLE;
            req_q         <= 1'b0;
            addr_q        <= RESET_PC;
            pc_f          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            hold_word_q   <= NOP_WORD;
            parked_q      <= 1'b0;
            valid_d       <= 1'b0;
            instr_d       <= NOP_WORD;
            pc_d          <= 32'd0;
            adel_q        <= 1'b0;
        end else begin
            // Decode moved on without a new word: leave a bubble behind.
            if (!stall_d) begin
                valid_d <= 1'b0;
                instr_d <= NOP_WORD;
                adel_q  <= 1'b0;
            end

            // Remember a redirect until the delay-slot fetch consumes it.
            if (redirect_d) begin
                pend_valid_q  <= 1'b1;
                pend_target_q <= target_d;
            end

            case (state_q)
                FS_IDLE: begin
                    state_q <= FS_WAIT;
                    req_q   <= 1'b1;
                    addr_q  <= pc_f;
                end

                FS_WAIT: begin
                    if (!req_q) begin
                        if (adel_hit) begin
                            // Present the bad address to decode as a flagged NOP and park.
                            if (!stall_d) begin
                                valid_d  <= 1'b1;
                                instr_d  <= NOP_WORD;
                                pc_d     <= pc_f;
                                adel_q   <= 1'b1;
                                parked_q <= 1'b1;
                                state_q  <= FS_HOLD;
                            end
                        end else begin
                            req_q  <= 1'b1;
                            addr_q <= pc_f;
                        end
                    end else if (imem.inst_data_ok) begin
                        req_q <= 1'b0;
                        if (!stall_d) begin
                            valid_d      <= 1'b1;
                            instr_d      <= imem.inst_rdata;
                            pc_d         <= pc_f;
                            adel_q       <= 1'b0;
                            pc_f         <= next_pc;
                            pend_valid_q <= 1'b0;
                        end else begin
                            hold_word_q <= imem.inst_rdata;
                            state_q     <= FS_HOLD;
                        end
                    end
                end

                FS_HOLD: begin
                    if (!parked_q && !stall_d) begin
                        valid_d      <= 1'b1;
                        instr_d      <= hold_word_q;
                        pc_d         <= pc_f;
                        adel_q       <= 1'b0;
                        pc_f         <= next_pc;
                        pend_valid_q <= 1'b0;
                        state_q      <= FS_WAIT;
                    end
                end

                FS_KILL: begin
                    // Swallow the stale response, then fetch the flush target.
                    if (imem.inst_data_ok) begin
                        req_q   <= 1'b0;
                        state_q <= FS_WAIT;
                    end
                end

                default: state_q <= FS_IDLE;
            endcase

            // Exception flush overrides all of the above.
            if (exc_flush) begin
                pc_f <= exc_pc;
                if (state_q != FS_KILL) begin
                    valid_d      <= 1'b0;
                    instr_d      <= NOP_WORD;
                    adel_q       <= 1'b0;
                    pend_valid_q <= 1'b0;
                    parked_q     <= 1'b0;
                    if (state_q == FS_WAIT && req_q && !imem.inst_data_ok) begin
                        state_q <= FS_KILL;
                    end else begin
                        state_q <= FS_WAIT;
                        req_q   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table and sequence checks for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_d;
    logic        redirect_d;
    logic [31:0] target_d;
    logic        exc_flush;
    logic [31:0] exc_pc;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        adel_d;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (imem),
        .stall_d    (stall_d),
        .redirect_d (redirect_d),
        .target_d   (target_d),
        .exc_flush  (exc_flush),
        .exc_pc     (exc_pc),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .adel_d     (adel_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        dok;
        logic [31:0] rdata;
        logic        red;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pcf;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcd;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pcd);
        chk({tag, " valid_d"}, {31'd0, valid_d}, {31'd0, v});
        chk({tag, " instr_d"}, instr_d, ins);
        chk({tag, " pc_d"}, pc_d, pcd);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        stall_d = 1'b0;
        redirect_d = 1'b0;
        target_d = 32'd0;
        exc_flush = 1'b0;
        exc_pc = 32'd0;
        imem.inst_data_ok = 1'b0;
        imem.inst_rdata = 32'd0;

        // Cycles 0..14 after reset: 1-cycle memory, branch at BFC00008 redirecting to BFC00100.
        //           dok  rdata          red  tgt            req  addr           pc_f           v  instr          pc_d
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00000, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00000, 32'hBFC00000, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b1, 32'h403FFFFF, 1'b0, 32'h0,        1'b1, 32'hBFC00000, 32'hBFC00000, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00004, 1'b1, 32'h403FFFFF, 32'hBFC00000};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00004, 32'hBFC00004, 1'b0, 32'h0,        32'hBFC00000};
        vecs[5]  = '{1'b1, 32'h403FFFFB, 1'b0, 32'h0,        1'b1, 32'hBFC00004, 32'hBFC00004, 1'b0, 32'h0,        32'hBFC00000};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00008, 1'b1, 32'h403FFFFB, 32'hBFC00004};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00008, 32'hBFC00008, 1'b0, 32'h0,        32'hBFC00004};
        vecs[8]  = '{1'b1, 32'h403FFFF7, 1'b0, 32'h0,        1'b1, 32'hBFC00008, 32'hBFC00008, 1'b0, 32'h0,        32'hBFC00004};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 32'hBFC00100, 1'b0, 32'h0,        32'hBFC0000C, 1'b1, 32'h403FFFF7, 32'hBFC00008};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC0000C, 32'hBFC0000C, 1'b0, 32'h0,        32'hBFC00008};
        vecs[11] = '{1'b1, 32'h403FFFF3, 1'b0, 32'h0,        1'b1, 32'hBFC0000C, 32'hBFC0000C, 1'b0, 32'h0,        32'hBFC00008};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00100, 1'b1, 32'h403FFFF3, 32'hBFC0000C};
        vecs[13] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00100, 32'hBFC00100, 1'b0, 32'h0,        32'hBFC0000C};
        vecs[14] = '{1'b1, 32'h403FFEFF, 1'b0, 32'h0,        1'b1, 32'hBFC00100, 32'hBFC00100, 1'b0, 32'h0,        32'hBFC0000C};

        repeat (3) @(posedge clk);
        #1;
        chk("rst inst_req", {31'd0, imem.inst_req}, 32'd0);
        chk("rst pc_f", pc_f, 32'hBFC00000);
        chk_ifid("rst", 1'b0, 32'h0, 32'h0);
        chk("rst adel_d", {31'd0, adel_d}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            imem.inst_data_ok = vecs[i].dok;
            imem.inst_rdata   = vecs[i].rdata;
            redirect_d        = vecs[i].red;
            target_d          = vecs[i].tgt;
            chk($sformatf("row%0d inst_req", i), {31'd0, imem.inst_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("row%0d inst_addr", i), imem.inst_addr, vecs[i].e_addr);
            chk($sformatf("row%0d pc_f", i), pc_f, vecs[i].e_pcf);
            chk_ifid($sformatf("row%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pcd);
            step();
        end

        // Stall across data_ok: word parks in the hold buffer, no refetch.
        imem.inst_data_ok = 1'b0;
        stall_d = 1'b1;
        chk_ifid("c15", 1'b1, 32'h403FFEFF, 32'hBFC00100);
        chk("c15 pcplus4_d", pcplus4_d, 32'hBFC00104);
        step();
        chk("c16 inst_addr", imem.inst_addr, 32'hBFC00104);
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h403FFEFB;
        step();
        imem.inst_data_ok = 1'b0;
        chk("c18 inst_req", {31'd0, imem.inst_req}, 32'd0);
        chk_ifid("c18", 1'b1, 32'h403FFEFF, 32'hBFC00100);
        step();
        chk("c19 inst_req", {31'd0, imem.inst_req}, 32'd0);
        step();
        stall_d = 1'b0;
        chk("c20 inst_req", {31'd0, imem.inst_req}, 32'd0);
        chk("c20 instr_d", instr_d, 32'h403FFEFF);
        step();
        chk_ifid("c21", 1'b1, 32'h403FFEFB, 32'hBFC00104);
        chk("c21 pc_f", pc_f, 32'hBFC00108);
        chk("c21 inst_req", {31'd0, imem.inst_req}, 32'd0);
        step();
        chk("c22 inst_addr", imem.inst_addr, 32'hBFC00108);

        // Redirect while a 4-cycle fetch is outstanding.
        step();
        redirect_d = 1'b1;
        target_d = 32'hBFC00200;
        step();
        redirect_d = 1'b0;
        chk("c24 inst_req", {31'd0, imem.inst_req}, 32'd1);
        chk("c24 inst_addr", imem.inst_addr, 32'hBFC00108);
        step();
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h403FFEF7;
        step();
        imem.inst_data_ok = 1'b0;
        chk("c27 pc_f", pc_f, 32'hBFC00200);
        chk_ifid("c27", 1'b1, 32'h403FFEF7, 32'hBFC00108);
        step();
        chk("c28 inst_addr", imem.inst_addr, 32'hBFC00200);
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h403FFDFF;
        step();
        imem.inst_data_ok = 1'b0;
        chk("c30 pc_f (pending clear)", pc_f, 32'hBFC00204);

        // Redirect latched, then flushed away by an exception mid-fetch.
        redirect_d = 1'b1;
        target_d = 32'hBFC00300;
        step();
        redirect_d = 1'b0;
        chk("c31 inst_addr", imem.inst_addr, 32'hBFC00204);
        step();
        exc_flush = 1'b1;
        exc_pc = 32'hBFC00380;
        step();
        exc_flush = 1'b0;
        chk("c33 inst_req held", {31'd0, imem.inst_req}, 32'd1);
        chk("c33 inst_addr held", imem.inst_addr, 32'hBFC00204);
        chk("c33 pc_f", pc_f, 32'hBFC00380);
        chk("c33 valid_d", {31'd0, valid_d}, 32'd0);
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h403FFDFB;
        step();
        imem.inst_data_ok = 1'b0;
        chk_ifid("c35 stale dropped", 1'b0, 32'h0, 32'hBFC00200);
        chk("c35 inst_req", {31'd0, imem.inst_req}, 32'd0);
        step();
        chk("c36 inst_addr", imem.inst_addr, 32'hBFC00380);
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h403FFC7F;
        step();
        imem.inst_data_ok = 1'b0;
        chk_ifid("c38", 1'b1, 32'h403FFC7F, 32'hBFC00380);
        chk("c38 pc_f (redirect discarded)", pc_f, 32'hBFC00384);

        // Flush with nothing outstanding, to the top of the address space.
        exc_flush = 1'b1;
        exc_pc = 32'hFFFFFFFC;
        step();
        exc_flush = 1'b0;
        chk("c39 valid_d", {31'd0, valid_d}, 32'd0);
        chk("c39 inst_req", {31'd0, imem.inst_req}, 32'd0);
        chk("c39 pc_f", pc_f, 32'hFFFFFFFC);
        step();
        chk("c40 inst_addr", imem.inst_addr, 32'hFFFFFFFC);
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h00000003;
        step();
        imem.inst_data_ok = 1'b0;
        chk("c42 pc_f wrap", pc_f, 32'h00000000);
        chk("c42 pcplus4_d wrap", pcplus4_d, 32'h00000000);
        chk_ifid("c42", 1'b1, 32'h00000003, 32'hFFFFFFFC);

        // Second flush while already killing only moves the PC.
        step();
        chk("c43 inst_addr", imem.inst_addr, 32'h00000000);
        exc_flush = 1'b1;
        exc_pc = 32'hBFC00380;
        step();
        exc_pc = 32'hBFC00400;
        step();
        exc_flush = 1'b0;
        chk("c45 inst_addr held", imem.inst_addr, 32'h00000000);
        chk("c45 pc_f", pc_f, 32'hBFC00400);
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h12345678;
        step();
        imem.inst_data_ok = 1'b0;
        chk("c46 inst_req", {31'd0, imem.inst_req}, 32'd0);
        chk("c46 valid_d", {31'd0, valid_d}, 32'd0);
        step();
        chk("c47 inst_addr", imem.inst_addr, 32'hBFC00400);

`ifdef FETCH_ADEL_CHECK_EN
        // Redirect to a misaligned target raises an address error without a request.
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h10000001;
        step();
        imem.inst_data_ok = 1'b0;
        chk("c49 pc_f", pc_f, 32'hBFC00404);
        redirect_d = 1'b1;
        target_d = 32'h00400002;
        step();
        redirect_d = 1'b0;
        chk("c50 inst_addr", imem.inst_addr, 32'hBFC00404);
        step();
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata = 32'h0;
        step();
        imem.inst_data_ok = 1'b0;
        chk("c52 pc_f", pc_f, 32'h00400002);
        step();
        chk("c53 inst_req", {31'd0, imem.inst_req}, 32'd0);
        chk("c53 adel_d", {31'd0, adel_d}, 32'd1);
        chk_ifid("c53", 1'b1, 32'h0, 32'h00400002);
        step();
        chk("c54 inst_req", {31'd0, imem.inst_req}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
